// File: rtl/mpc_admm_iter_sched.sv
// mpc_admm_iter_sched: sequences the x-, z- and u-update pipelines of an ADMM
// solve for a fixed number of iterations under an ap_ctrl-style handshake.
// Optional feature: define MPC_ADMM_EARLY_EXIT_EN to end the solve early when
// conv_ok is high in the CHECK cycle. Default build ignores conv_ok.
module mpc_admm_iter_sched #(
  parameter int ITER_W = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  input  logic [ITER_W-1:0] iter_max,
  output logic              x_start,
  output logic              z_start,
  output logic              u_start,
  input  logic              x_done,
  input  logic              z_done,
  input  logic              u_done,
  input  logic              conv_ok,
  output logic [ITER_W-1:0] iter_count,
  output logic              proto_err
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START_X = 4'd1,
    WAIT_X  = 4'd2,
    START_Z = 4'd3,
    WAIT_Z  = 4'd4,
    START_U = 4'd5,
    WAIT_U  = 4'd6,
    CHECK   = 4'd7,
    DONE    = 4'd8
  } state_t;

  state_t            state_r;
  state_t            state_n;
  logic [ITER_W-1:0] limit_r;
  logic [ITER_W-1:0] iter_cnt_r;
  logic [ITER_W-1:0] iter_inc_s;
  logic              proto_err_r;
  logic              viol_s;
  logic              ap_done_r;
  logic              ap_idle_r;
  logic              x_start_r;
  logic              z_start_r;
  logic              u_start_r;

`ifndef MPC_ADMM_EARLY_EXIT_EN
  // conv_ok has no effect in this build; tie it off explicitly.
  logic unused_conv_ok_s;
  assign unused_conv_ok_s = conv_ok;
`endif

  // Count after the iteration currently being checked; the limit test uses it
  // so that iter_count stops exactly at the limit and can never wrap.
  assign iter_inc_s = iter_cnt_r + {{(ITER_W-1){1'b0}}, 1'b1};

  // Next-state logic of the iteration sequencer.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (ap_start) begin
          if (iter_max == {ITER_W{1'b0}}) state_n = DONE;
          else                            state_n = START_X;
        end else begin
          state_n = IDLE;
        end
      end
      START_X: state_n = WAIT_X;
      WAIT_X: begin
        if (x_done) state_n = START_Z;
        else        state_n = WAIT_X;
      end
      START_Z: state_n = WAIT_Z;
      WAIT_Z: begin
        if (z_done) state_n = START_U;
        else        state_n = WAIT_Z;
      end
      START_U: state_n = WAIT_U;
      WAIT_U: begin
        if (u_done) state_n = CHECK;
        else        state_n = WAIT_U;
      end
      CHECK: begin
`ifdef MPC_ADMM_EARLY_EXIT_EN
        if ((iter_inc_s == limit_r) || conv_ok) state_n = DONE;
        else                                    state_n = START_X;
`else
        if (iter_inc_s == limit_r) state_n = DONE;
        else                       state_n = START_X;
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A done pulse is illegal outside its own WAIT state, and so is any overlap.
  always_comb begin
    viol_s = 1'b0;
    if ((x_done && (state_r != WAIT_X)) ||
        (z_done && (state_r != WAIT_Z)) ||
        (u_done && (state_r != WAIT_U)) ||
        (x_done && z_done) || (x_done && u_done) || (z_done && u_done)) begin
      viol_s = 1'b1;
    end else begin
      viol_s = 1'b0;
    end
  end

  // State, limit/count, sticky error and outputs registered from the next state
  // so every output pulse lines up with the state it belongs to.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_r     <= IDLE;
      limit_r     <= {ITER_W{1'b0}};
      iter_cnt_r  <= {ITER_W{1'b0}};
      proto_err_r <= 1'b0;
      ap_done_r   <= 1'b0;
      ap_idle_r   <= 1'b1;
      x_start_r   <= 1'b0;
      z_start_r   <= 1'b0;
      u_start_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      if ((state_r == IDLE) && ap_start) begin
        limit_r    <= iter_max;
        iter_cnt_r <= {ITER_W{1'b0}};
      end else if (state_r == CHECK) begin
        limit_r    <= limit_r;
        iter_cnt_r <= iter_inc_s;
      end else begin
        limit_r    <= limit_r;
        iter_cnt_r <= iter_cnt_r;
      end
      proto_err_r <= proto_err_r | viol_s;
      ap_done_r   <= (state_n == DONE);
      ap_idle_r   <= (state_n == IDLE);
      x_start_r   <= (state_n == START_X);
      z_start_r   <= (state_n == START_Z);
      u_start_r   <= (state_n == START_U);
    end
  end

  assign ap_done    = ap_done_r;
  assign ap_ready   = ap_done_r;
  assign ap_idle    = ap_idle_r;
  assign x_start    = x_start_r;
  assign z_start    = z_start_r;
  assign u_start    = u_start_r;
  assign iter_count = iter_cnt_r;
  assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_mpc_admm_iter_sched.sv
// Directed bench for mpc_admm_iter_sched: automatic pipeline responder,
// pulse monitors and a linear sequence of checked steps.
module tb_mpc_admm_iter_sched;

  logic       ap_clk;
  logic       ap_rst_n;
  logic       ap_start;
  logic       ap_done;
  logic       ap_ready;
  logic       ap_idle;
  logic [7:0] iter_max;
  logic       x_start, z_start, u_start;
  logic       x_done, z_done, u_done;
  logic       conv_ok;
  logic [7:0] iter_count;
  logic       proto_err;

  logic resp_x, resp_z, resp_u;
  logic man_x, man_z, man_u;
  logic resp_en;
  logic conv_en;
  int   nx, nz, nu, nd;
  int   errors, checks;

  assign x_done  = resp_x | man_x;
  assign z_done  = resp_z | man_z;
  assign u_done  = resp_u | man_u;
  assign conv_ok = conv_en && (iter_count == 8'd3);

  mpc_admm_iter_sched #(.ITER_W(8)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
    .iter_max(iter_max), .x_start(x_start), .z_start(z_start),
    .u_start(u_start), .x_done(x_done), .z_done(z_done), .u_done(u_done),
    .conv_ok(conv_ok), .iter_count(iter_count), .proto_err(proto_err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Pipeline model: answers each start pulse with a done pulse 5 ticks later.
  initial begin
    int cx, cz, cu;
    cx = 0; cz = 0; cu = 0;
    resp_x = 1'b0; resp_z = 1'b0; resp_u = 1'b0;
    forever begin
      @(posedge ap_clk); #1;
      resp_x = 1'b0; resp_z = 1'b0; resp_u = 1'b0;
      if (!ap_rst_n || !resp_en) begin
        cx = 0; cz = 0; cu = 0;
      end else begin
        if (cx > 0) begin cx--; if (cx == 0) resp_x = 1'b1; end
        if (cz > 0) begin cz--; if (cz == 0) resp_z = 1'b1; end
        if (cu > 0) begin cu--; if (cu == 0) resp_u = 1'b1; end
        if (x_start) cx = 5;
        if (z_start) cz = 5;
        if (u_start) cu = 5;
      end
    end
  end

  // Pulse counters sampled mid-cycle.
  initial begin
    nx = 0; nz = 0; nu = 0; nd = 0;
    forever begin
      @(negedge ap_clk);
      if (x_start) nx++;
      if (z_start) nz++;
      if (u_start) nu++;
      if (ap_done) nd++;
    end
  end

  task automatic tick();
    @(posedge ap_clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (ap_done !== 1'b1 && n < budget) begin tick(); n++; end
    check(tag, {31'd0, ap_done}, 32'd1);
  endtask

  initial begin
    int bx, bz, bu, bd, n, dn;
    logic [31:0] exp_conv;
    errors = 0; checks = 0;
    ap_rst_n = 1'b0; ap_start = 1'b0; iter_max = 8'd0;
    man_x = 1'b0; man_z = 1'b0; man_u = 1'b0;
    resp_en = 1'b0; conv_en = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_idle", {31'd0, ap_idle}, 32'd1);
    check("rst_cnt", {24'd0, iter_count}, 32'd0);
    check("rst_err", {31'd0, proto_err}, 32'd0);
    check("rst_done", {31'd0, ap_done}, 32'd0);
    check("rst_xs", {31'd0, x_start}, 32'd0);
    ap_rst_n = 1'b1;
    tick();

    // Zero-iteration solve: DONE directly, no pipeline starts
    bx = nx; bz = nz; bu = nu;
    iter_max = 8'd0; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    check("z0_done", {31'd0, ap_done}, 32'd1);
    check("z0_ready", {31'd0, ap_ready}, 32'd1);
    check("z0_idle", {31'd0, ap_idle}, 32'd0);
    check("z0_cnt", {24'd0, iter_count}, 32'd0);
    tick();
    check("z0_idle2", {31'd0, ap_idle}, 32'd1);
    check("z0_done2", {31'd0, ap_done}, 32'd0);
    check("z0_starts", nx + nz + nu - bx - bz - bu, 32'd0);

    // Three-iteration solve with 5-cycle pipelines
    resp_en = 1'b1;
    bx = nx; bz = nz; bu = nu; bd = nd;
    iter_max = 8'd3; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    check("i3_lat_xs", {31'd0, x_start}, 32'd1);
    wait_done("i3_timeout", 300);
    check("i3_ready", {31'd0, ap_ready}, 32'd1);
    check("i3_cnt", {24'd0, iter_count}, 32'd3);
    tick();
    check("i3_nx", nx - bx, 32'd3);
    check("i3_nz", nz - bz, 32'd3);
    check("i3_nu", nu - bu, 32'd3);
    check("i3_nd", nd - bd, 32'd1);
    check("i3_err", {31'd0, proto_err}, 32'd0);
    check("i3_idle", {31'd0, ap_idle}, 32'd1);
    iter_max = 8'd7;
    tick(); tick(); tick();
    check("i3_hold", {24'd0, iter_count}, 32'd3);

    // conv_ok high during the 4th iteration, limit 10
`ifdef MPC_ADMM_EARLY_EXIT_EN
    exp_conv = 32'd4;
`else
    exp_conv = 32'd10;
`endif
    conv_en = 1'b1;
    bx = nx;
    iter_max = 8'd10; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    wait_done("cv_timeout", 2000);
    check("cv_cnt", {24'd0, iter_count}, exp_conv);
    tick();
    check("cv_nx", nx - bx, exp_conv);
    conv_en = 1'b0;

    // Stray z_done while in WAIT_X
    resp_en = 1'b0;
    bz = nz;
    iter_max = 8'd1; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    check("pe_xs", {31'd0, x_start}, 32'd1);
    tick();
    man_z = 1'b1;
    tick();
    man_z = 1'b0;
    check("pe_set", {31'd0, proto_err}, 32'd1);
    tick(); tick(); tick();
    check("pe_stay_err", {31'd0, proto_err}, 32'd1);
    check("pe_no_zs", nz - bz, 32'd0);
    check("pe_busy", {31'd0, ap_idle}, 32'd0);
    man_x = 1'b1;
    tick();
    man_x = 1'b0;
    check("pe_zs", {31'd0, z_start}, 32'd1);
    tick();
    man_z = 1'b1;
    tick();
    man_z = 1'b0;
    check("pe_us", {31'd0, u_start}, 32'd1);
    tick();
    man_u = 1'b1;
    tick();
    man_u = 1'b0;
    tick();
    check("pe_done", {31'd0, ap_done}, 32'd1);
    check("pe_cnt", {24'd0, iter_count}, 32'd1);
    check("pe_sticky", {31'd0, proto_err}, 32'd1);
    tick();

    // Reset during WAIT_Z of iteration 2, then a clean run
    resp_en = 1'b1;
    iter_max = 8'd3; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    n = 0;
    while (!(z_start === 1'b1 && iter_count == 8'd1) && n < 300) begin tick(); n++; end
    check("mr_reach", {31'd0, z_start}, 32'd1);
    tick();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    check("mr_idle", {31'd0, ap_idle}, 32'd1);
    check("mr_cnt", {24'd0, iter_count}, 32'd0);
    check("mr_err", {31'd0, proto_err}, 32'd0);
    bd = nd;
    for (int i = 0; i < 20; i++) tick();
    check("mr_nodone", nd - bd, 32'd0);
    check("mr_err2", {31'd0, proto_err}, 32'd0);
    iter_max = 8'd2; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    wait_done("mr_timeout", 300);
    check("mr_cnt2", {24'd0, iter_count}, 32'd2);
    check("mr_err3", {31'd0, proto_err}, 32'd0);
    tick();

    // ap_start held high, one iteration per solve, back-to-back
    bd = nd; bx = nx;
    iter_max = 8'd1; ap_start = 1'b1;
    dn = 0; n = 0;
    while (dn < 3 && n < 300) begin
      tick(); n++;
      if (ap_done === 1'b1) begin
        dn++;
        tick(); n++;
        check("bb_idle", {31'd0, ap_idle}, 32'd1);
        check("bb_done_low", {31'd0, ap_done}, 32'd0);
        tick(); n++;
        check("bb_restart", {31'd0, x_start}, 32'd1);
      end
    end
    check("bb_solves", dn, 32'd3);
    ap_start = 1'b0;
    wait_done("bb_timeout", 300);
    tick();
    check("bb_nd", nd - bd, 32'd4);
    check("bb_nx", nx - bx, 32'd4);
    check("bb_err", {31'd0, proto_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
